mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  N-port front end for the single-port data memory. Generalises the old 2-way address mux (port 0 writes, port 1 reads).
//  Any port may read or write. A request/grant handshake arbitrates between ports.
//  Each read result goes back only to the port that issued it, after a fixed memory latency.
//  Sits between the datapath/DMA requesters and the synchronous RAM macro.
// PARAMETERS
//  NUM_PORTS  2  number of requester ports (2..8)
//  ADDR_W     6  memory address width
//  DATA_W     8  memory data width
//  RD_LAT     1  memory read latency in cycles, mem_q valid RD_LAT cycles after address (1..4)
//  ARB_MODE   0  0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  reset      in   1                 synchronous, active-high reset
//  port_req   in   NUM_PORTS         per-port access request, held until granted
//  port_we    in   NUM_PORTS         per-port 1 = write, 0 = read
//  port_addr  in   NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
//  port_wdata in   NUM_PORTS*DATA_W  packed write data, port i at [i*DATA_W +: DATA_W]
//  port_gnt   out  NUM_PORTS         one-hot grant, same cycle as the accepted request
//  port_rvalid out NUM_PORTS         one-hot read-return strobe
//  port_rdata out  DATA_W            read data, valid when any port_rvalid bit is set
//  mem_addr   out  ADDR_W            address to RAM
//  mem_we     out  1                 write enable to RAM
//  mem_data   out  DATA_W            write data to RAM
//  mem_q      in   DATA_W            read data from RAM
// BEHAVIOUR
//  Reset
//  - rr_ptr=0; tag pipe cleared; port_rvalid=0.
//  - While reset=1: port_gnt=0, mem_we=0.
//  Arbitration (combinational, every cycle)
//  - At most one grant. port_gnt is one-hot or zero; zero iff port_req==0.
//  - RR mode: search starts at rr_ptr, wraps NUM_PORTS-1 -> 0; first requester wins.
//  - RR mode pointer: on a grant to port k, rr_ptr <= (k+1) mod NUM_PORTS. On an idle cycle rr_ptr holds.
//  - FP mode: lowest index with req=1 wins; rr_ptr unused.
//  Memory drive (combinational from the granted port)
//  - mem_addr/mem_data/mem_we = granted port's addr/wdata/we.
//  - No grant: mem_we=0; mem_addr/mem_data = port 0 values (don't-care but stable).
//  Handshake
//  - Transfer occurs when port_req[i] & port_gnt[i] are both high at a clock edge.
//  - Requester keeps req/we/addr/wdata stable until granted.
//  - Requester may drop req before grant (request withdrawn, no access).
//  - Back-to-back requests from one port are allowed: one access per cycle, 100% throughput.
//  Read return
//  - Tag pipe is RD_LAT stages of {valid, port index}. A granted read shifts in {1, k}; any other cycle shifts in {0, x}.
//  - Pipe output drives port_rvalid (decoded one-hot) and port_rdata=mem_q.
//  - Return arrives exactly RD_LAT cycles after the grant edge.
//  - Writes produce no rvalid. Writes have no response; complete at the grant edge.
//  - Read and write to the same address in consecutive cycles: the read returns the RAM value.
//    No bypass or forwarding; RAM read-during-write behaviour applies.
//  Boundaries
//  - Reset asserted mid-flight: all in-flight reads are discarded; no rvalid for them after reset.
//  - Reset is sampled in the same cycle as a request: no grant, no memory write.
//  - NUM_PORTS=1: port 0 always granted on req; rr_ptr is constant 0.
// STRUCTURE
//  - Shared include mem_if_defs.vh holds:
//    - `MEM_ARB_RR=0, `MEM_ARB_FP=1
//    - default ADDR_W/DATA_W
//    - clog2 helper macro for the port index width
//  - Sub-module rr_arbiter (params N, MODE): req, ptr -> one-hot gnt and encoded index.
//  - Top keeps rr_ptr register, grant mux, tag pipe and rvalid decode.
// TESTING
//  1. Reset: reset=1 for 2 cycles with all req=1 -> port_gnt=0, mem_we=0, port_rvalid=0.
//     After release, first grant goes to port 0.
//  2. Single write then read, NUM_PORTS=2, RD_LAT=1:
//     - p1 writes 0xA5 @0x12 -> gnt[1], mem_we=1, mem_addr=0x12.
//     - Next cycle p0 reads 0x12 -> one cycle later rvalid=2'b01, rdata=0xA5.
//  3. RR fairness, NUM_PORTS=4, all req held high 8 cycles -> grant order 0,1,2,3,0,1,2,3.
//     After p2 only requests (1 cycle), next all-req cycle grants p3.
//  4. FP mode, NUM_PORTS=4, req=4'b1010 -> gnt=4'b0010 every cycle until p1 drops.
//     Then gnt=4'b1000.
//  5. RD_LAT=3, reads p0@0x01, p1@0x02, p0@0x03 on consecutive cycles:
//     - rvalid sequence 01,10,01 starting 3 cycles after the first grant.
//     - rdata matches the RAM model.
//  6. Reset mid-flight: RD_LAT=3, grant a read, assert reset 1 cycle later -> no rvalid in the following 5 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and helpers for the multi-port memory front end:
// arbitration mode codes, default bus widths and the port-index width helper.
package mem_port_arbiter_pkg;

    localparam int MEM_ARB_RR = 0;
    localparam int MEM_ARB_FP = 1;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    // Width of an encoded port index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Single-grant arbiter: picks the requester closest to ptr (round-robin) or the
// lowest requesting index (fixed priority), returning one-hot and encoded grant.
module rr_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int MODE  = MEM_ARB_RR,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam bit IS_FP = (MODE == MEM_ARB_FP);

    int   best_d_s;
    logic take_s;

    // Search distance of port p from the start of the priority order.
    function automatic int prio_dist(input int p, input logic [IDX_W-1:0] q);
        return IS_FP ? p : ((p - int'(q) + N) % N);
    endfunction

    // Winner selection: smallest search distance among active requesters.
    always_comb begin
        best_d_s = N;
        take_s   = 1'b0;
        idx      = '0;
        for (int p = 0; p < N; p++) begin
            take_s   = req[p] && (prio_dist(p, ptr) < best_d_s);
            best_d_s = take_s ? prio_dist(p, ptr) : best_d_s;
            idx      = take_s ? IDX_W'(p) : idx;
        end
    end

    // One-hot expansion of the encoded winner.
    always_comb begin
        any = |req;
        gnt = '0;
        for (int p = 0; p < N; p++) begin
            gnt[p] = any && (idx == IDX_W'(p));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port front end for the single-port data memory: arbitrates requesters,
// drives the RAM from the winner and routes each read result back to its issuer.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int ARB_MODE  = MEM_ARB_RR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic [NUM_PORTS-1:0]          port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
    output logic [NUM_PORTS-1:0]          port_gnt,
    output logic [NUM_PORTS-1:0]          port_rvalid,
    output logic [DATA_W-1:0]             port_rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_data,
    input  logic [DATA_W-1:0]             mem_q
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam bit IS_RR = (ARB_MODE == MEM_ARB_RR);

    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     rr_ptr_nxt_s;
    logic [NUM_PORTS-1:0] arb_gnt_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 arb_any_s;
    logic                 gnt_vld_s;
    logic                 gnt_rd_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic                 sel_we_s;

    logic [RD_LAT-1:0]    tag_vld_r;
    logic [IDX_W-1:0]     tag_idx_r [RD_LAT];

    rr_arbiter #(
        .N     (NUM_PORTS),
        .MODE  (ARB_MODE),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (port_req),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s),
        .idx (gnt_idx_s),
        .any (arb_any_s)
    );

    // Grant suppression while reset is held, so no access can slip through.
    always_comb begin
        if (reset) begin
            port_gnt  = '0;
            gnt_vld_s = 1'b0;
        end else begin
            port_gnt  = arb_gnt_s;
            gnt_vld_s = arb_any_s;
        end
    end

    // AND-OR select of the granted port's request fields.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        sel_we_s   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_addr_s = sel_addr_s | ({ADDR_W{port_gnt[i]}} & port_addr[i*ADDR_W +: ADDR_W]);
            sel_data_s = sel_data_s | ({DATA_W{port_gnt[i]}} & port_wdata[i*DATA_W +: DATA_W]);
            sel_we_s   = sel_we_s | (port_gnt[i] & port_we[i]);
        end
    end

    // RAM drive; idle cycles park the bus on port 0 with the write disabled.
    always_comb begin
        if (gnt_vld_s) begin
            mem_addr = sel_addr_s;
            mem_data = sel_data_s;
            mem_we   = sel_we_s;
        end else begin
            mem_addr = port_addr[ADDR_W-1:0];
            mem_data = port_wdata[DATA_W-1:0];
            mem_we   = 1'b0;
        end
        gnt_rd_s = gnt_vld_s & ~sel_we_s;
    end

    // Pointer successor: the port after the winner, wrapping to 0.
    always_comb begin
        if (gnt_idx_s == IDX_W'(NUM_PORTS - 1)) begin
            rr_ptr_nxt_s = '0;
        end else begin
            rr_ptr_nxt_s = gnt_idx_s + IDX_W'(1);
        end
    end

    // Round-robin pointer; holds on idle cycles and stays 0 in priority mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (IS_RR && gnt_vld_s) begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Read tag pipe: one stage per cycle of RAM latency, so the tag and mem_q line up.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_r <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_idx_r[s] <= '0;
            end
        end else begin
            tag_vld_r[0] <= gnt_rd_s;
            tag_idx_r[0] <= gnt_idx_s;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_idx_r[s] <= tag_idx_r[s-1];
            end
        end
    end

    // Return strobe decode from the last tag stage.
    always_comb begin
        port_rvalid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_rvalid[i] = tag_vld_r[RD_LAT-1] && (tag_idx_r[RD_LAT-1] == IDX_W'(i));
        end
    end

    assign port_rdata = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a 4-port round-robin instance with
// RD_LAT=3 and a 4-port fixed-priority instance with RD_LAT=1, checked against a reference model.
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;

    logic [NP-1:0]    req    [2];
    logic [NP-1:0]    we     [2];
    logic [NP*AW-1:0] addr   [2];
    logic [NP*DW-1:0] wdata  [2];
    logic [NP-1:0]    gnt    [2];
    logic [NP-1:0]    rvalid [2];
    logic [DW-1:0]    rdata  [2];
    logic [AW-1:0]    mem_addr [2];
    logic             mem_we   [2];
    logic [DW-1:0]    mem_data [2];
    logic [DW-1:0]    mem_q    [2];

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset(reset), .port_req(req[0]), .port_we(we[0]), .port_addr(addr[0]),
        .port_wdata(wdata[0]), .port_gnt(gnt[0]), .port_rvalid(rvalid[0]), .port_rdata(rdata[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_data(mem_data[0]), .mem_q(mem_q[0]));

    mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ARB_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .port_req(req[1]), .port_we(we[1]), .port_addr(addr[1]),
        .port_wdata(wdata[1]), .port_gnt(gnt[1]), .port_rvalid(rvalid[1]), .port_rdata(rdata[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_data(mem_data[1]), .mem_q(mem_q[1]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic bit fp_of(input int i);
        return (i == 1);
    endfunction

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 29 + 7) & 255);
    endfunction

    // Synchronous RAM with a configurable read pipeline (read-before-write).
    logic [DW-1:0] ram [2][64];
    logic [DW-1:0] qp  [2][4];
    bit ram_ready = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            qp[i][0] <= ram[i][mem_addr[i]];
            for (int s = 1; s < 4; s++) qp[i][s] <= qp[i][s-1];
            if (!ram_ready) begin
                for (int a = 0; a < 64; a++) ram[i][a] <= init_val(a);
            end else if (mem_we[i]) begin
                ram[i][mem_addr[i]] <= mem_data[i];
            end
        end
        ram_ready <= 1'b1;
    end

    always_comb begin
        mem_q[0] = qp[0][2];
        mem_q[1] = qp[1][0];
    end

    // Reference model state
    int            rr_ptr [2];
    logic [DW-1:0] shadow [2][64];
    bit            sv [2][8];
    int            sp [2][8];
    logic [DW-1:0] sd [2][8];
    logic [NP-1:0] exp_gnt [2];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NP-1:0] model_gnt(input int i);
        logic [NP-1:0] one;
        int start;
        int p;
        one = 4'b0001;
        if (reset) return '0;
        start = fp_of(i) ? 0 : rr_ptr[i];
        for (int k = 0; k < NP; k++) begin
            p = (start + k) % NP;
            if (req[i][p]) return one << p;
        end
        return '0;
    endfunction

    // Check every output of both instances against the model, then advance one cycle.
    task automatic tick();
        logic [NP-1:0] g;
        logic [NP-1:0] one;
        logic [AW-1:0] a;
        int gp;
        int slot;
        one = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            g = model_gnt(i);
            exp_gnt[i] = g;
            gp = -1;
            for (int p = 0; p < NP; p++) if (g[p]) gp = p;
            chk($sformatf("gnt%0d", i), gnt[i], g);
            if (gp >= 0) begin
                chk($sformatf("mem_we%0d", i), mem_we[i], we[i][gp]);
                chk($sformatf("mem_addr%0d", i), mem_addr[i], addr[i][gp*AW +: AW]);
                chk($sformatf("mem_data%0d", i), mem_data[i], wdata[i][gp*DW +: DW]);
            end else begin
                chk($sformatf("idle_we%0d", i), mem_we[i], 1'b0);
                chk($sformatf("idle_addr%0d", i), mem_addr[i], addr[i][AW-1:0]);
                chk($sformatf("idle_data%0d", i), mem_data[i], wdata[i][DW-1:0]);
            end
            slot = cyc % 8;
            if (cyc > 0) begin
                chk($sformatf("rvalid%0d", i), rvalid[i], sv[i][slot] ? (one << sp[i][slot]) : 4'b0000);
                if (sv[i][slot]) chk($sformatf("rdata%0d", i), rdata[i], sd[i][slot]);
            end
            if (reset) begin
                rr_ptr[i] = 0;
                for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
            end else begin
                sv[i][slot] = 1'b0;
                if (gp >= 0) begin
                    rr_ptr[i] = (gp + 1) % NP;
                    a = addr[i][gp*AW +: AW];
                    if (we[i][gp]) begin
                        shadow[i][a] = wdata[i][gp*DW +: DW];
                    end else begin
                        sv[i][(cyc + lat_of(i)) % 8] = 1'b1;
                        sp[i][(cyc + lat_of(i)) % 8] = gp;
                        sd[i][(cyc + lat_of(i)) % 8] = shadow[i][a];
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_port(input int i, input int p, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i][p] = r;
        we[i][p] = w;
        addr[i][p*AW +: AW] = a;
        wdata[i][p*DW +: DW] = d;
    endtask

    task automatic clr(input int i);
        req[i] = '0;
        we[i] = '0;
        addr[i] = '0;
        wdata[i] = '0;
    endtask

    // Pending requests stay stable until granted (occasionally withdrawn); others re-roll.
    task automatic rand_drive();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (req[i][p] && !exp_gnt[i][p]) begin
                    if ($urandom_range(9) == 0) req[i][p] = 1'b0;
                end else begin
                    set_port(i, p, ($urandom_range(9) < 6), 1'($urandom_range(1)),
                             AW'($urandom_range(7)), DW'($urandom));
                end
            end
        end
    endtask

    initial begin
        logic [NP-1:0] one;
        logic [NP-1:0] seq [3];
        one = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            rr_ptr[i] = 0;
            exp_gnt[i] = '0;
            for (int a = 0; a < 64; a++) shadow[i][a] = init_val(a);
            for (int s = 0; s < 8; s++) begin
                sv[i][s] = 1'b0;
                sp[i][s] = 0;
                sd[i][s] = '0;
            end
            clr(i);
            req[i] = 4'b1111;
        end

        // Reset held two cycles with every port requesting
        reset = 1'b1;
        #1;
        chk("rst_gnt_a", gnt[0], 4'b0000);
        chk("rst_gnt_b", gnt[1], 4'b0000);
        chk("rst_we_a", mem_we[0], 1'b0);
        tick();
        #1;
        chk("rst_rvalid_a", rvalid[0], 4'b0000);
        chk("rst_rvalid_b", rvalid[1], 4'b0000);
        tick();
        reset = 1'b0;
        clr(1);

        // Round-robin fairness with all ports requesting reads
        for (int p = 0; p < NP; p++) set_port(0, p, 1'b1, 1'b0, AW'(p + 8), 8'h00);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_order", gnt[0], one << (k % NP));
            tick();
        end
        req[0] = 4'b0100;
        #1;
        chk("rr_p2_only", gnt[0], 4'b0100);
        tick();
        req[0] = 4'b1111;
        #1;
        chk("rr_after_p2", gnt[0], 4'b1000);
        tick();
        clr(0);

        // Fixed priority: port 1 beats port 3 until it drops
        set_port(1, 1, 1'b1, 1'b0, 6'h04, 8'h00);
        set_port(1, 3, 1'b1, 1'b0, 6'h05, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fp_1010", gnt[1], 4'b0010);
            tick();
        end
        req[1][1] = 1'b0;
        #1;
        chk("fp_1000", gnt[1], 4'b1000);
        tick();
        clr(1);

        // Write then read-back through the RD_LAT=1 instance
        set_port(1, 1, 1'b1, 1'b1, 6'h12, 8'hA5);
        #1;
        chk("wr_gnt", gnt[1], 4'b0010);
        chk("wr_we", mem_we[1], 1'b1);
        chk("wr_addr", mem_addr[1], 6'h12);
        tick();
        clr(1);
        set_port(1, 0, 1'b1, 1'b0, 6'h12, 8'h00);
        #1;
        chk("rd_gnt", gnt[1], 4'b0001);
        chk("rd_we", mem_we[1], 1'b0);
        tick();
        clr(1);
        #1;
        chk("rd_rvalid", rvalid[1], 4'b0001);
        chk("rd_rdata", rdata[1], 8'hA5);
        tick();

        // Back-to-back reads on the RD_LAT=3 instance
        set_port(0, 0, 1'b1, 1'b0, 6'h01, 8'h00);
        #1;
        tick();
        clr(0);
        set_port(0, 1, 1'b1, 1'b0, 6'h02, 8'h00);
        #1;
        tick();
        clr(0);
        set_port(0, 0, 1'b1, 1'b0, 6'h03, 8'h00);
        #1;
        tick();
        clr(0);
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lat3_rvalid", rvalid[0], seq[k]);
            chk("lat3_rdata", rdata[0], shadow[0][k + 1]);
            tick();
        end

        // Reset one cycle after a read grant discards the return
        set_port(0, 2, 1'b1, 1'b0, 6'h05, 8'h00);
        #1;
        tick();
        clr(0);
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("midflight_rv", rvalid[0], 4'b0000);
            tick();
        end

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            rand_drive();
            #1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
